l2_act_sequencer: RTL and testbench

L2_ACT_SEQUENCER -- requirements
Module: l2_act_sequencer

---
 rtl/l2_act_sequencer_pkg.sv | 18 +
 rtl/l2_act_sequencer_relu_requant.sv | 27 ++
 rtl/l2_act_sequencer.sv | 138 +++++++++++++
 tb/tb_l2_act_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_act_sequencer_pkg.sv
// Shared constants and FSM encoding for the layer-2 activation sequencer.
package l2_act_sequencer_pkg;

  localparam int N_HID     = 32;
  localparam int N_OUT     = 10;
  localparam int ACC_W     = 20;
  localparam int ACT_W     = 8;
  localparam int SHIFT_DEF = 7;
  localparam int W_ADDR_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/l2_act_sequencer_relu_requant.sv
// ReLU followed by truncating right-shift and saturation to the int8 range 0..127.
module relu_requant
  import l2_act_sequencer_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [ACT_W-1:0] act_o
);

  localparam logic signed [ACC_W-1:0] SAT_LIM = ACC_W'(127);

  logic signed [ACC_W-1:0] shifted_s;

  // Clamp negatives to zero, saturate large positives at 127
  always_comb begin
    shifted_s = acc_i >>> SHIFT;
    if (acc_i[ACC_W-1]) begin
      act_o = 8'sd0;
    end else if (shifted_s > SAT_LIM) begin
      act_o = 8'sd127;
    end else begin
      act_o = shifted_s[ACT_W-1:0];
    end
  end

endmodule

// File: rtl/l2_act_sequencer.sv
// Sequences one layer-2 pass: bias load, N_HID prefetched MAC steps, then a done pulse.
module l2_act_sequencer
  import l2_act_sequencer_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEF,
  parameter int N_HID = l2_act_sequencer_pkg::N_HID
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [ACC_W-1:0] l1_acc [N_HID],
  output logic                    mac_clr,
  output logic                    mac_init_bias,
  output logic                    mac_en,
  output logic signed [ACT_W-1:0] activation,
  output logic [W_ADDR_W-1:0]     w_addr,
  output logic                    busy,
  output logic                    done
);

  localparam int              CNT_W    = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_HID - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rst_prev_q;
  logic                    clr_q;
  logic                    accept_s;
  logic signed [ACT_W-1:0] act_req_s [N_HID];
  logic signed [ACT_W-1:0] act_buf_q [N_HID];

  for (genvar g = 0; g < N_HID; g++) begin : g_rq
    relu_requant #(.SHIFT(SHIFT)) u_rq (
      .acc_i (l1_acc[g]),
      .act_o (act_req_s[g])
    );
  end

  assign accept_s = (state_q == ST_IDLE) && start;

  // State, step counter and the one-shot accumulator clear after reset release
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clr_q   <= rst_prev_q;
    end
    rst_prev_q <= rst;
  end

  // Activation buffer loads only on an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      act_buf_q <= '{default: '0};
    end else if (accept_s) begin
      act_buf_q <= act_req_s;
    end else begin
      act_buf_q <= act_buf_q;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = ST_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          state_d = ST_RUN;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode; w_addr runs one row ahead to cover the ROM read latency
  always_comb begin
    mac_clr       = 1'b0;
    mac_init_bias = 1'b0;
    mac_en        = 1'b0;
    activation    = 8'sd0;
    w_addr        = '0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy    = 1'b0;
        mac_clr = clr_q;
      end
      ST_INIT: begin
        mac_init_bias = 1'b1;
      end
      ST_RUN: begin
        mac_en     = 1'b1;
        activation = act_buf_q[cnt_q];
        if (cnt_q == CNT_LAST) begin
          w_addr = '0;
        end else begin
          w_addr = W_ADDR_W'(cnt_q + CNT_W'(1));
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_l2_act_sequencer.sv
// Directed bench for l2_act_sequencer with a small ROM + MAC-array model for end-to-end logits.
module tb_l2_act_sequencer;
  import l2_act_sequencer_pkg::*;

  typedef struct {
    logic signed [ACC_W-1:0] acc;
    logic signed [ACT_W-1:0] act;
  } rq_vec_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic signed [ACC_W-1:0] l1_acc [N_HID];
  logic                    mac_clr, mac_init_bias, mac_en, busy, done;
  logic signed [ACT_W-1:0] activation;
  logic [W_ADDR_W-1:0]     w_addr;

  int n_run  = 0;
  int n_fail = 0;

  logic signed [ACT_W-1:0] wrom [N_HID][N_OUT];
  logic signed [ACT_W-1:0] rom_row_q [N_OUT];
  int                      bias [N_OUT];
  int                      mac_acc [N_OUT];

  l2_act_sequencer #(.SHIFT(7), .N_HID(N_HID)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .l1_acc        (l1_acc),
    .mac_clr       (mac_clr),
    .mac_init_bias (mac_init_bias),
    .mac_en        (mac_en),
    .activation    (activation),
    .w_addr        (w_addr),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Synchronous weight ROM (1-cycle latency) feeding ten MACs
  always @(posedge clk) begin
    for (int j = 0; j < N_OUT; j++) begin
      rom_row_q[j] <= wrom[w_addr][j];
      if (mac_clr) mac_acc[j] <= 0;
      else if (mac_init_bias) mac_acc[j] <= bias[j];
      else if (mac_en) mac_acc[j] <= mac_acc[j] + int'(activation) * int'(rom_row_q[j]);
    end
  end

  function automatic int ref_act(input int x);
    if (x < 0) return 0;
    if (x / 128 > 127) return 127;
    return x / 128;
  endfunction

  task automatic check(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic start_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, inout int cyc);
    int lim;
    lim = cyc + 100;
    while (done !== 1'b1 && cyc < lim) begin
      tick();
      cyc++;
    end
    check({name, " done seen"}, done, 1);
  endtask

  initial begin
    rq_vec_t rq_tab [14];
    int      cyc, n_done, done_at, nz, exp_a;
    int      exp_logit [N_OUT];
    int      done_q [$];
    int      init_q [$];
    int      idle_q [$];

    rq_tab = '{
      '{-20'sd500,     8'sd0},   '{20'sd0,       8'sd0},
      '{20'sd1000,     8'sd7},   '{20'sd16383,   8'sd127},
      '{20'sd16384,    8'sd127}, '{20'sd20000,   8'sd127},
      '{20'sh80000,    8'sd0},   '{20'sd127,     8'sd0},
      '{20'sd128,      8'sd1},   '{20'sd255,     8'sd1},
      '{20'sd12800,    8'sd100}, '{20'sd16256,   8'sd127},
      '{20'shFFFFF,    8'sd0},   '{20'sd524287,  8'sd127}
    };
    for (int k = 0; k < N_HID; k++) begin
      l1_acc[k] = '0;
      for (int j = 0; j < N_OUT; j++) wrom[k][j] = 8'sd1;
    end
    for (int j = 0; j < N_OUT; j++) bias[j] = 0;

    // Reset state and the post-release clear pulse
    rst = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst mac_en", mac_en, 0);
    check("rst init_bias", mac_init_bias, 0);
    check("rst activation", activation, 0);
    check("rst w_addr", w_addr, 0);
    rst = 1'b0;
    check("clr before release", mac_clr, 0);
    tick();
    check("clr after release", mac_clr, 1);
    check("clr idle", busy, 0);
    tick();
    check("clr single cycle", mac_clr, 0);

    // Requant table: one vector per hidden lane, read back as the RUN stream
    for (int i = 0; i < N_HID; i++) l1_acc[i] = (i < 14) ? rq_tab[i].acc : 20'sd0;
    start_pass();
    tick();
    for (int i = 0; i < N_HID; i++) begin
      check($sformatf("requant lane %0d", i), activation, (i < 14) ? int'(rq_tab[i].act) : 0);
      tick();
    end
    check("requant pass done", done, 1);
    tick();

    // Full pass timing with l1_acc[i] = i*128; inputs changed after capture
    for (int i = 0; i < N_HID; i++) l1_acc[i] = ACC_W'(i * 128);
    start_pass();
    for (int i = 0; i < N_HID; i++) l1_acc[i] = 20'sd16383;
    check("c1 init_bias", mac_init_bias, 1);
    check("c1 mac_en", mac_en, 0);
    check("c1 busy", busy, 1);
    check("c1 w_addr", w_addr, 0);
    for (int c = 2; c <= 33; c++) begin
      tick();
      check($sformatf("c%0d act", c), activation, c - 2);
      check($sformatf("c%0d w_addr", c), w_addr, (c == 33) ? 0 : c - 1);
      check($sformatf("c%0d en", c), {mac_en, mac_init_bias, done}, 3'b100);
    end
    tick();
    check("c34 done", done, 1);
    check("c34 mac_en", mac_en, 0);
    check("c34 activation", activation, 0);
    check("c34 busy", busy, 1);
    tick();
    check("c35 busy", busy, 0);
    check("c35 done", done, 0);

    // Start while busy is ignored
    for (int i = 0; i < N_HID; i++) l1_acc[i] = ACC_W'((31 - i) * 128);
    cyc = 1;
    start_pass();
    while (cyc < 10) begin tick(); cyc++; end
    start = 1'b1;
    for (int i = 0; i < N_HID; i++) l1_acc[i] = '0;
    tick();
    cyc++;
    start = 1'b0;
    n_done = 0;
    done_at = -1;
    while (cyc < 45) begin
      if (mac_en) check($sformatf("busy-start c%0d act", cyc), activation, 31 - (cyc - 2));
      if (done) begin n_done++; done_at = cyc; end
      tick();
      cyc++;
    end
    check("busy-start done count", n_done, 1);
    check("busy-start done cycle", done_at, 34);

    // Reset mid-RUN, then restart in the clear cycle
    for (int i = 0; i < N_HID; i++) l1_acc[i] = ACC_W'((i + 1) * 128);
    cyc = 1;
    start_pass();
    while (cyc < 15) begin tick(); cyc++; end
    check("pre-rst mac_en", mac_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("c16 busy", busy, 0);
    check("c16 mac_en", mac_en, 0);
    check("c16 mac_clr", mac_clr, 0);
    nz = 0;
    for (int i = 0; i < N_HID; i++) if (dut.act_buf_q[i] != 8'sd0) nz++;
    check("c16 act_buf nonzero", nz, 0);
    tick();
    check("c17 mac_clr", mac_clr, 1);
    for (int i = 0; i < N_HID; i++) l1_acc[i] = 20'sd640;
    cyc = 17;
    start_pass();
    cyc++;
    check("c18 init_bias", mac_init_bias, 1);
    check("c18 mac_clr", mac_clr, 0);
    tick();
    cyc++;
    check("c19 act", activation, 5);
    wait_done("rst-restart", cyc);
    check("rst-restart done cycle", cyc, 51);
    tick();

    // Start held high: back-to-back passes with one IDLE cycle between
    for (int i = 0; i < N_HID; i++) l1_acc[i] = 20'sd384;
    start = 1'b1;
    tick();
    cyc = 1;
    while (cyc <= 72) begin
      if (mac_init_bias) init_q.push_back(cyc);
      if (done) done_q.push_back(cyc);
      if (!busy) idle_q.push_back(cyc);
      tick();
      cyc++;
    end
    start = 1'b0;
    check("held done count", done_q.size(), 2);
    check("held init count", init_q.size(), 3);
    check("held idle count", idle_q.size(), 2);
    check("held done0", (done_q.size() > 0) ? done_q[0] : -1, 34);
    check("held idle0", (idle_q.size() > 0) ? idle_q[0] : -1, 35);
    check("held init1", (init_q.size() > 1) ? init_q[1] : -1, 36);
    check("held done1", (done_q.size() > 1) ? done_q[1] : -1, 69);
    reset_dut();

    // End-to-end: unit weights, bias 5, activation 2 everywhere
    for (int j = 0; j < N_OUT; j++) bias[j] = 5;
    for (int i = 0; i < N_HID; i++) l1_acc[i] = 20'sd256;
    cyc = 1;
    start_pass();
    wait_done("e2e unit", cyc);
    check("e2e unit done cycle", cyc, 34);
    for (int j = 0; j < N_OUT; j++) check($sformatf("e2e unit logit %0d", j), mac_acc[j], 69);
    tick();

    // End-to-end with row-dependent weights exercises the address prefetch
    for (int k = 0; k < N_HID; k++)
      for (int j = 0; j < N_OUT; j++) wrom[k][j] = ACT_W'(((k + 2 * j) % 7) - 3);
    for (int j = 0; j < N_OUT; j++) begin
      bias[j] = j - 4;
      exp_logit[j] = j - 4;
    end
    for (int i = 0; i < N_HID; i++) begin
      l1_acc[i] = (i % 5 == 0) ? -20'sd300 : ACC_W'(i * 700);
      exp_a = ref_act((i % 5 == 0) ? -300 : i * 700);
      for (int j = 0; j < N_OUT; j++) exp_logit[j] += exp_a * (((i + 2 * j) % 7) - 3);
    end
    cyc = 1;
    start_pass();
    wait_done("e2e mixed", cyc);
    for (int j = 0; j < N_OUT; j++) check($sformatf("e2e mixed logit %0d", j), mac_acc[j], exp_logit[j]);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
